kmeans_centroid_update_k2_d3: RTL and testbench
===============================================

# kmeans_centroid_update_k2_d3

Centroid-update stage of the k-means engine for 2 centroids and 3 dimensions, the consumer of the assignment pipeline's output stream. It accepts the per-point stream (data point plus selected centroid index) and accumulates per-centroid dimension sums and point counts over one epoch. At epoch end it divides each sum by its count with a sequential divider and publishes the new centroids, which are fed back as the next epoch's centroid inputs.

## Interface
- `input_data_width`, 16, width of each unsigned coordinate.
- `count_width`, 16, width of each per-centroid point counter.
- `acc_width`, `input_data_width+count_width`, width of each sum accumulator and of the divider.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  a point is present on `input_data*` and `selected_centroid` this cycle.
- `in_last`  in  1  qualified by `in_valid`; marks the final point of the epoch.
- `input_data0..2`  in  `input_data_width`  point coordinates, unsigned.
- `selected_centroid`  in  1  assigned centroid index (0 or 1).
- `busy`  out  1  high in DIVIDE; points are not accepted while high.
- `out_valid`  out  1  one-cycle pulse: new centroids are valid.
- `centroid0_d0..d2`, `centroid1_d0..d2`  out  `input_data_width`  current centroids, held between updates.

## Operation
- FSM states: ACCUM (reset state) and DIVIDE.
- ACCUM:
  - A point is accepted on any edge with `in_valid && !busy`.
  - Accepting a point adds its coordinates into `sum_k<s>_d0..2` and increments `cnt_k<s>`, where s = `selected_centroid`.
- The epoch ends on accepting a point with `in_last=1`, or on accepting a point that brings any `cnt_k` to 2^count_width−1 (forced end). On the same edge: that point is accumulated and the FSM enters DIVIDE.
- DIVIDE:
  - Performs 6 divisions in fixed order k0d0, k0d1, k0d2, k1d0, k1d1, k1d2.
  - Each division is `sum_k*_d* / cnt_k*` in an unsigned restoring divider: 1 load cycle plus `acc_width` iteration cycles.
  - The quotient is truncated to `input_data_width`. It cannot exceed the largest coordinate seen, so no overflow occurs.
- Empty cluster (`cnt_k`=0): the divider still runs for fixed latency, but the result is discarded and that centroid's outputs keep their previous values.
- Completion edge, all in one edge:
  - Quotients are written to the centroid output registers.
  - `out_valid` is pulsed.
  - All sums and counts clear to 0.
  - The FSM returns to ACCUM.
- Inputs with `in_valid` during DIVIDE are ignored (dropped, not buffered). Upstream must honour `busy`.
- Widths:
  - Sums zero-extend coordinates to `acc_width`.
  - Counts are `count_width` bits and cannot wrap because of the forced epoch end.
- Reset:
  - Applies at any time, including mid-DIVIDE, and aborts the operation.
  - State → ACCUM; all sums, counts and divider state → 0.
  - All centroid outputs → 0; `out_valid`=0, `busy`=0.

## Timing
- Accumulation: a point accepted at edge N is reflected in the accumulators after edge N. This gives a throughput of one point per cycle in ACCUM.
- `busy` rises 1 cycle after the edge that accepts the epoch-ending point.
- DIVIDE duration: 6×(`acc_width`+1) cycles, which is 198 with defaults.
- `out_valid` is high for exactly one cycle, starting 6×(`acc_width`+1) cycles after the epoch-ending edge (198 with defaults). `busy` is low in that same cycle.
- The cycle in which `out_valid` is high is an ACCUM cycle, so a point may be accepted in it. That point starts the next epoch.
- Centroid outputs change only on the completion edge or on reset.

## Configuration
- `KMEANS_CENTROID_ROUNDING_EN`
  - Defined: the dividend is `sum + (cnt >> 1)`, giving round-half-up mean. The accumulator carries one extra guard bit so the addition cannot overflow.
  - Undefined: the dividend is `sum`, giving the truncated mean.
- Latency is identical in both builds.

## Structure
- Shared package `kmeans_pkg` holds:
  - centroid/dimension count constants (K=2, D=3);
  - the FSM state enum;
  - the `acc_width` derivation.
- Sub-module `kmeans_seq_divider`:
  - unsigned restoring divider parameterised by width;
  - handshake `start`/`done`;
  - one quotient bit per cycle.
- It is instantiated once and time-multiplexed across the 6 divisions by a division-index counter (0..5).

## Test plan
- Points (10,20,30) and (20,40,50) to k0, the second with `in_last` → after 198 cycles `out_valid`=1, centroid0=(15,30,40), centroid1=(0,0,0).
- k1 points with d0 = 1 and 2 (`in_last` on the second) → centroid1_d0 = 1 without the macro, 2 with `KMEANS_CENTROID_ROUNDING_EN`.
- Epoch 1 gives centroid1=(100,100,100). Epoch 2 sends all points to k0 → centroid1 is still (100,100,100) after `out_valid`.
- Drive `in_valid` every cycle during DIVIDE → `busy`=1 throughout, and the next epoch's sums exclude those points.
- Assert `rst` 50 cycles into DIVIDE → next cycle all centroids are 0, `busy`=0, and no `out_valid` pulse is ever produced for the aborted epoch.
- With `count_width`=4: 15 points to k0, none with `in_last`, coordinate 0xFFFF → forced epoch end, centroid0_d0=0xFFFF.

Source files
------------

// File: rtl/kmeans_pkg.sv
// kmeans_pkg: constants and types shared by the k-means centroid-update stage.
//   K / D            : number of centroids and dimensions.
//   NUM_DIV          : divisions performed per epoch (one per centroid coordinate).
//   DEFAULT_*        : default coordinate and counter widths.
//   acc_width_f()    : derives the accumulator/divider width from both widths.
//   state_e          : update FSM states.
package kmeans_pkg;

  localparam int K       = 2;
  localparam int D       = 3;
  localparam int NUM_DIV = K * D;

  localparam int DEFAULT_INPUT_DATA_WIDTH = 16;
  localparam int DEFAULT_COUNT_WIDTH      = 16;

  // A sum of up to 2^count_width-1 coordinates fits in the two widths added.
  function automatic int acc_width_f(input int input_data_width, input int count_width);
    return input_data_width + count_width;
  endfunction

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_DIVIDE = 1'b1
  } state_e;

endpackage

// File: rtl/kmeans_seq_divider.sv
// kmeans_seq_divider: unsigned restoring divider, one quotient bit per cycle.
//   clk, rst  : clock, synchronous active-high reset.
//   start     : load cycle; dividend/divisor are captured on this edge.
//   dividend  : WIDTH+1 bits. The top bit is preloaded into the partial
//               remainder, so the caller must guarantee quotient < 2^WIDTH.
//   divisor   : WIDTH bits.
//   done      : high in the last iteration cycle; quotient is valid with it.
//   quotient  : low OUT_WIDTH bits of the quotient completed on that edge.
// Latency: 1 load cycle + WIDTH iteration cycles.
module kmeans_seq_divider #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH:0]       dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] quotient
);

  localparam int                ITER_W    = $clog2(WIDTH);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

  logic              active_q, active_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  // Holds the unconsumed dividend bits in the top and shifts quotient bits in at the bottom.
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [WIDTH:0]    trial, diff;
  logic              fits;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    trial    = {rem_q, quo_q[WIDTH-1]};
    diff     = trial - {1'b0, dvs_q};
    fits     = (trial >= {1'b0, dvs_q});
    active_d = active_q;
    iter_d   = iter_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    if (start) begin
      active_d = 1'b1;
      iter_d   = '0;
      rem_d    = WIDTH'(dividend[WIDTH]);
      quo_d    = dividend[WIDTH-1:0];
      dvs_d    = divisor;
    end else if (active_q) begin
      rem_d  = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_d  = {quo_q[WIDTH-2:0], fits};
      iter_d = iter_q + ITER_W'(1);
      if (iter_q == LAST_ITER) active_d = 1'b0;
    end
  end

  assign done     = active_q && (iter_q == LAST_ITER);
  assign quotient = quo_d[OUT_WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      iter_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
    end else begin
      active_q <= active_d;
      iter_q   <= iter_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
    end
  end

endmodule

// File: rtl/kmeans_centroid_update_k2_d3.sv
// kmeans_centroid_update_k2_d3: per-epoch centroid update for K=2, D=3.
//   clk, rst                  : clock, synchronous active-high reset.
//   in_valid, in_last         : point strobe and end-of-epoch marker.
//   input_data0..2            : unsigned point coordinates.
//   selected_centroid         : centroid the point was assigned to.
//   busy                      : high while dividing; points are dropped.
//   out_valid                 : one-cycle pulse when new centroids are loaded.
//   centroid{0,1}_d{0,1,2}    : current centroids, held between updates.
// Optional build macro KMEANS_CENTROID_ROUNDING_EN: round-half-up means
// (dividend = sum + cnt/2) instead of truncated means. Latency is unchanged.
module kmeans_centroid_update_k2_d3
  import kmeans_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = DEFAULT_INPUT_DATA_WIDTH,
  parameter int COUNT_WIDTH      = DEFAULT_COUNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic [INPUT_DATA_WIDTH-1:0] input_data0,
  input  logic [INPUT_DATA_WIDTH-1:0] input_data1,
  input  logic [INPUT_DATA_WIDTH-1:0] input_data2,
  input  logic                        selected_centroid,
  output logic                        busy,
  output logic                        out_valid,
  output logic [INPUT_DATA_WIDTH-1:0] centroid0_d0,
  output logic [INPUT_DATA_WIDTH-1:0] centroid0_d1,
  output logic [INPUT_DATA_WIDTH-1:0] centroid0_d2,
  output logic [INPUT_DATA_WIDTH-1:0] centroid1_d0,
  output logic [INPUT_DATA_WIDTH-1:0] centroid1_d1,
  output logic [INPUT_DATA_WIDTH-1:0] centroid1_d2
);

  localparam int AW = acc_width_f(INPUT_DATA_WIDTH, COUNT_WIDTH);
  localparam int DW = AW + 1;  // guard bit for the rounding offset
  // Accepting a point while a count holds this value saturates it: forced epoch end.
  localparam logic [COUNT_WIDTH-1:0] CNT_FORCE = {COUNT_WIDTH{1'b1}} - COUNT_WIDTH'(1);
  localparam logic [2:0]             LAST_DIV  = 3'(NUM_DIV - 1);

  logic [INPUT_DATA_WIDTH-1:0] in_pt [D];
  assign in_pt[0] = input_data0;
  assign in_pt[1] = input_data1;
  assign in_pt[2] = input_data2;

  state_e                      state_q, state_d;
  logic [AW-1:0]               sum_q [K][D], sum_d [K][D];
  logic [COUNT_WIDTH-1:0]      cnt_q [K], cnt_d [K];
  logic [2:0]                  div_idx_q, div_idx_d;
  logic                        start_q, start_d;
  logic [INPUT_DATA_WIDTH-1:0] res_q [NUM_DIV], res_d [NUM_DIV];
  logic [INPUT_DATA_WIDTH-1:0] cen_q [K][D], cen_d [K][D];
  logic                        out_valid_q, out_valid_d;

  logic [AW-1:0]               div_sum;
  logic [COUNT_WIDTH-1:0]      div_cnt;
  logic [DW-1:0]               div_dividend;
  logic                        div_done;
  logic [INPUT_DATA_WIDTH-1:0] div_quotient;

  // Operand mux: the single divider is shared across the six divisions.
  always_comb begin
    div_sum = '0;
    div_cnt = '0;
    for (int k = 0; k < K; k++) begin
      for (int d = 0; d < D; d++) begin
        if (div_idx_q == 3'(k * D + d)) begin
          div_sum = sum_q[k][d];
          div_cnt = cnt_q[k];
        end
      end
    end
`ifdef KMEANS_CENTROID_ROUNDING_EN
    div_dividend = {1'b0, div_sum} + DW'(div_cnt >> 1);
`else
    div_dividend = {1'b0, div_sum};
`endif
  end

  kmeans_seq_divider #(
    .WIDTH     (AW),
    .OUT_WIDTH (INPUT_DATA_WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start_q),
    .dividend (div_dividend),
    .divisor  (AW'(div_cnt)),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    div_idx_d   = div_idx_q;
    start_d     = 1'b0;
    res_d       = res_q;
    cen_d       = cen_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          for (int d = 0; d < D; d++) begin
            sum_d[selected_centroid][d] = sum_q[selected_centroid][d] + AW'(in_pt[d]);
          end
          cnt_d[selected_centroid] = cnt_q[selected_centroid] + COUNT_WIDTH'(1);
          if (in_last || (cnt_q[selected_centroid] == CNT_FORCE)) begin
            state_d   = ST_DIVIDE;
            div_idx_d = '0;
            start_d   = 1'b1;
          end
        end
      end
      ST_DIVIDE: begin
        // Points arriving now are dropped: sums and counts stay frozen so the
        // divider operands remain stable for the whole DIVIDE phase.
        if (div_done) begin
          res_d[div_idx_q] = div_quotient;
          if (div_idx_q == LAST_DIV) begin
            for (int k = 0; k < K; k++) begin
              for (int d = 0; d < D; d++) begin
                // An empty cluster keeps its previous centroid.
                if (cnt_q[k] != '0) cen_d[k][d] = res_d[k * D + d];
                sum_d[k][d] = '0;
              end
              cnt_d[k] = '0;
            end
            out_valid_d = 1'b1;
            state_d     = ST_ACCUM;
          end else begin
            div_idx_d = div_idx_q + 3'd1;
            start_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // NOTE: these register arrays are architectural state (accumulators and
  // visible centroids), so every entry is reset, not just the control flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      div_idx_q   <= '0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < K; k++) begin
        cnt_q[k] <= '0;
        for (int d = 0; d < D; d++) begin
          sum_q[k][d] <= '0;
          cen_q[k][d] <= '0;
        end
      end
      for (int i = 0; i < NUM_DIV; i++) res_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      div_idx_q   <= div_idx_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      cen_q       <= cen_d;
    end
  end

  assign busy         = (state_q == ST_DIVIDE);
  assign out_valid    = out_valid_q;
  assign centroid0_d0 = cen_q[0][0];
  assign centroid0_d1 = cen_q[0][1];
  assign centroid0_d2 = cen_q[0][2];
  assign centroid1_d0 = cen_q[1][0];
  assign centroid1_d1 = cen_q[1][1];
  assign centroid1_d2 = cen_q[1][2];

endmodule

// File: tb/tb_kmeans_centroid_update_k2_d3.sv
// tb_kmeans_centroid_update_k2_d3: scoreboard bench for the centroid-update stage.
// A reference model keeps per-cluster sums/counts as plain integers and pushes
// the expected centroid set on each epoch end; a negedge monitor pops and
// compares whenever out_valid is seen. A second instance with a 4-bit counter
// exercises the forced epoch end.
module tb_kmeans_centroid_update_k2_d3;

  typedef logic [5:0][15:0] cen_vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, selected_centroid;
  logic [15:0] input_data0, input_data1, input_data2;
  logic        busy, out_valid;
  logic [15:0] c0d0, c0d1, c0d2, c1d0, c1d1, c1d2;

  logic        b_in_valid, b_in_last, b_sel;
  logic [15:0] b_data0, b_data1, b_data2;
  logic        b_busy, b_out_valid;
  logic [15:0] b_c0d0, b_c0d1, b_c0d2, b_c1d0, b_c1d1, b_c1d2;

  int       tests = 0;
  int       fails = 0;
  cen_vec_t exp_q[$];
  longint   msum [2][3];
  longint   mcnt [2];
  longint   mcen [2][3];

  always #5 clk = ~clk;

  kmeans_centroid_update_k2_d3 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
    .input_data0(input_data0), .input_data1(input_data1), .input_data2(input_data2),
    .selected_centroid(selected_centroid), .busy(busy), .out_valid(out_valid),
    .centroid0_d0(c0d0), .centroid0_d1(c0d1), .centroid0_d2(c0d2),
    .centroid1_d0(c1d0), .centroid1_d1(c1d1), .centroid1_d2(c1d2)
  );

  kmeans_centroid_update_k2_d3 #(.COUNT_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_last(b_in_last),
    .input_data0(b_data0), .input_data1(b_data1), .input_data2(b_data2),
    .selected_centroid(b_sel), .busy(b_busy), .out_valid(b_out_valid),
    .centroid0_d0(b_c0d0), .centroid0_d1(b_c0d1), .centroid0_d2(b_c0d2),
    .centroid1_d0(b_c1d0), .centroid1_d1(b_c1d1), .centroid1_d2(b_c1d2)
  );

  task automatic check(input string name, input longint actual, input longint expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding epoch.
  always @(negedge clk) begin
    cen_vec_t got, want;
    if (!rst && out_valid) begin
      got = {c1d2, c1d1, c1d0, c0d2, c0d1, c0d0};
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        want = exp_q.pop_front();
        for (int i = 0; i < 6; i++)
          check($sformatf("centroid%0d_d%0d", i / 3, i % 3), got[i], want[i]);
      end
    end
  end

  task automatic send(input int d0, input int d1, input int d2, input int sel, input bit last);
    @(negedge clk);
    in_valid          = 1'b1;
    in_last           = last;
    input_data0       = 16'(d0);
    input_data1       = 16'(d1);
    input_data2       = 16'(d2);
    selected_centroid = sel[0];
    msum[sel][0] += d0;
    msum[sel][1] += d1;
    msum[sel][2] += d2;
    mcnt[sel]++;
  endtask

  task automatic clear_model_sums();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0;
      for (int d = 0; d < 3; d++) msum[k][d] = 0;
    end
  endtask

  // Called right after the epoch-ending point is driven. Predicts the means,
  // then walks the 198-cycle divide window (optionally flooding the input).
  task automatic finish_epoch(input bit flood);
    cen_vec_t e;
    int       bad = 0;
    for (int k = 0; k < 2; k++) begin
      for (int d = 0; d < 3; d++) begin
        if (mcnt[k] != 0) begin
`ifdef KMEANS_CENTROID_ROUNDING_EN
          mcen[k][d] = (msum[k][d] + mcnt[k] / 2) / mcnt[k];
`else
          mcen[k][d] = msum[k][d] / mcnt[k];
`endif
        end
        e[k * 3 + d] = 16'(mcen[k][d]);
      end
    end
    exp_q.push_back(e);
    clear_model_sums();
    for (int i = 0; i < 198; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || out_valid !== 1'b0) bad++;
      if (flood) begin
        in_valid          = 1'b1;
        in_last           = 1'($urandom_range(0, 1));
        input_data0       = 16'($urandom);
        input_data1       = 16'($urandom);
        input_data2       = 16'($urandom);
        selected_centroid = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("busy_window_errors", bad, 0);
    check("out_valid_at_198", out_valid, 1);
    check("busy_low_at_done", busy, 0);
    @(negedge clk);
    check("out_valid_single_cycle", out_valid, 0);
  endtask

  task automatic random_epoch(input bit flood);
    int n = $urandom_range(1, 8);
    for (int i = 0; i < n; i++)
      send($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535),
           $urandom_range(0, 1), i == n - 1);
    finish_epoch(flood);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int n, pulses;
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; selected_centroid = 1'b0;
    input_data0 = '0; input_data1 = '0; input_data2 = '0;
    b_in_valid = 1'b0; b_in_last = 1'b0; b_sel = 1'b0;
    b_data0 = '0; b_data1 = '0; b_data2 = '0;
    clear_model_sums();
    for (int k = 0; k < 2; k++) for (int d = 0; d < 3; d++) mcen[k][d] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_centroids", {c0d0, c0d1, c0d2, c1d0, c1d1, c1d2}, 0);

    // Two k0 points: mean (15,30,40), k1 empty stays 0.
    send(10, 20, 30, 0, 1'b0);
    send(20, 40, 50, 0, 1'b1);
    finish_epoch(1'b0);
    check("dir_c0d0", c0d0, 15);
    check("dir_c0d2", c0d2, 40);
    check("dir_c1d0", c1d0, 0);

    // Mean 1.5 on k1 d0: truncation vs round-half-up.
    send(1, 7, 9, 1, 1'b0);
    send(2, 8, 9, 1, 1'b1);
    finish_epoch(1'b0);
`ifdef KMEANS_CENTROID_ROUNDING_EN
    check("round_c1d0", c1d0, 2);
`else
    check("round_c1d0", c1d0, 1);
`endif

    // Empty-cluster hold: k1 = 100s, then an epoch with k0 only.
    for (int i = 0; i < 3; i++) send(100, 100, 100, 1, i == 2);
    finish_epoch(1'b0);
    for (int i = 0; i < 4; i++) send($urandom_range(0, 65535), 5, 6, 0, i == 3);
    finish_epoch(1'b0);
    check("hold_c1d0", c1d0, 100);
    check("hold_c1d2", c1d2, 100);

    // Inputs during DIVIDE must be dropped; the following epoch proves it.
    random_epoch(1'b1);
    random_epoch(1'b0);
    for (int i = 0; i < 6; i++) random_epoch(1'($urandom_range(0, 1)));

    // Reset 50 cycles into DIVIDE aborts the epoch without a pulse.
    send(500, 600, 700, 0, 1'b0);
    send(900, 800, 700, 1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (49) @(negedge clk);
    check("busy_before_abort", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_centroids", {c0d0, c0d1, c0d2, c1d0, c1d1, c1d2}, 0);
    rst = 1'b0;
    clear_model_sums();
    for (int k = 0; k < 2; k++) for (int d = 0; d < 3; d++) mcen[k][d] = 0;
    pulses = 0;
    repeat (250) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    random_epoch(1'b0);

    // Forced end on the 4-bit-count instance: 15th point saturates cnt_k0.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      b_in_valid = 1'b1; b_in_last = 1'b0; b_sel = 1'b0;
      b_data0 = 16'hFFFF; b_data1 = 16'(i); b_data2 = 16'd3;
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    check("small_busy", b_busy, 1);
    n = 1;
    while (!b_out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("small_latency", n, 6 * 21 + 1);
    check("small_c0d0", b_c0d0, 16'hFFFF);
    check("small_c0d1", b_c0d1, 7);
    check("small_c0d2", b_c0d2, 3);
    check("small_c1d0", b_c1d0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
